// File: rtl/audio_pkg.sv
// Shared types and constants for the audio sample sink.
package audio_pkg;

    localparam int SAMPLE_W = 11;

    typedef logic [SAMPLE_W-1:0] audio_sample_t;

    typedef enum logic {
        IDLE = 1'b0,
        ACK  = 1'b1
    } sink_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO; dout always shows the head entry, valid while empty=0.
module sync_fifo #(
    parameter int W     = 11,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [W-1:0]             din,
    output logic [W-1:0]             dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   level_q, level_d;
    logic          do_push, do_pop;

    assign full    = (level_q == (AW+1)'(DEPTH));
    assign empty   = (level_q == '0);
    assign level   = level_q;
    assign dout    = mem_q[rd_ptr_q];

    // A pop frees a slot in the same cycle, so a full FIFO may still take a push.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({do_push, do_pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // NOTE: storage is deliberately not reset; pointers and level decide what is valid.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/audio_sample_sink.sv
// Audio port consumer: req/ack handshake into a FIFO, fixed-rate pop, PWM playback.
module audio_sample_sink
    import audio_pkg::*;
#(
    parameter int FIFO_DEPTH = 16,
    parameter int TICK_DIV   = 6250
) (
    input  logic                          clkFPGA,
    input  logic                          rst,
    input  logic [SAMPLE_W-1:0]           R6_audio,
    input  logic                          R14_flag,
    output logic                          R13_flag,
    output logic                          pwm_out,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          underrun
);

    localparam int TW = $clog2(TICK_DIV);

    logic          req_meta_q, req_s_q;
    sink_state_t   state_q, state_d;
    logic          ack_q, ack_d;
    logic [TW-1:0] tick_cnt_q, tick_cnt_d;
    logic          tick;
    audio_sample_t pwm_cnt_q;
    audio_sample_t cur_sample_q, cur_sample_d;
    logic          pwm_q;
    logic          underrun_q;

    logic          fifo_push, fifo_pop, fifo_full, fifo_empty;
    audio_sample_t fifo_dout;

    sync_fifo #(
        .W     (SAMPLE_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clkFPGA),
        .rst   (rst),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (R6_audio),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    assign tick       = (tick_cnt_q == TW'(TICK_DIV - 1));
    assign tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;
    assign fifo_pop   = tick && !fifo_empty;

    always_comb begin
        state_d   = state_q;
        ack_d     = ack_q;
        fifo_push = 1'b0;
        case (state_q)
            IDLE: begin
                // A full FIFO stalls the request; it is retried every cycle, never dropped.
                if (req_s_q && (!fifo_full || fifo_pop)) begin
                    fifo_push = 1'b1;
                    ack_d     = 1'b1;
                    state_d   = ACK;
                end
            end
            ACK: begin
                if (!req_s_q) begin
                    ack_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign cur_sample_d = fifo_pop ? fifo_dout : cur_sample_q;

    always_ff @(posedge clkFPGA) begin
        if (rst) begin
            req_meta_q   <= 1'b0;
            req_s_q      <= 1'b0;
            state_q      <= IDLE;
            ack_q        <= 1'b0;
            tick_cnt_q   <= '0;
            pwm_cnt_q    <= '0;
            cur_sample_q <= '0;
            pwm_q        <= 1'b0;
            underrun_q   <= 1'b0;
        end else begin
            req_meta_q   <= R14_flag;
            req_s_q      <= req_meta_q;
            state_q      <= state_d;
            ack_q        <= ack_d;
            tick_cnt_q   <= tick_cnt_d;
            pwm_cnt_q    <= pwm_cnt_q + 1'b1;
            cur_sample_q <= cur_sample_d;
            pwm_q        <= (pwm_cnt_q < cur_sample_q);
            if (tick && fifo_empty) underrun_q <= 1'b1;
        end
    end

    assign R13_flag = ack_q;
    assign pwm_out  = pwm_q;
    assign underrun = underrun_q;

endmodule

// File: tb/tb_audio_sample_sink.sv
// Directed bench for audio_sample_sink: handshake table plus full/duty/underrun/reset sequences.
module tb_audio_sample_sink;
    import audio_pkg::*;

    localparam int DEPTH = 16;
    localparam int TDIV  = 4096;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                r14 = 1'b0;
    logic [SAMPLE_W-1:0] r6  = '0;
    logic                r13;
    logic                pwm;
    logic [LW-1:0]       level;
    logic                underrun;

    int n_vec = 0;
    int n_bad = 0;
    int edge_n = 0;

    audio_sample_sink #(
        .FIFO_DEPTH (DEPTH),
        .TICK_DIV   (TDIV)
    ) dut (
        .clkFPGA    (clk),
        .rst        (rst),
        .R6_audio   (r6),
        .R14_flag   (r14),
        .R13_flag   (r13),
        .pwm_out    (pwm),
        .fifo_level (level),
        .underrun   (underrun)
    );

    always #5 clk = ~clk;

    // Edges since reset release; a playback tick lands on every multiple of TDIV.
    always @(posedge clk) edge_n <= rst ? 0 : edge_n + 1;

    typedef struct {
        logic                req;
        logic [SAMPLE_W-1:0] data;
        int                  edges;
        logic                exp_ack;
        int                  exp_level;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        r14 = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wait_ack(input logic v);
        int k = 0;
        while (r13 !== v && k < 16) begin
            @(negedge clk);
            k++;
        end
        check(v ? "ack_rise" : "ack_fall", {31'b0, r13}, {31'b0, v});
    endtask

    task automatic push(input logic [SAMPLE_W-1:0] d);
        r6  = d;
        r14 = 1'b1;
        wait_ack(1'b1);
        r14 = 1'b0;
        wait_ack(1'b0);
    endtask

    task automatic wait_to_edge(input int t);
        while (edge_n < t) @(negedge clk);
    endtask

    task automatic measure(output int hi);
        hi = 0;
        repeat (2048) begin
            @(negedge clk);
            if (pwm === 1'b1) hi++;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int hi;

        vecs[0] = '{1'b1, 11'h400, 2,  1'b0, 0};
        vecs[1] = '{1'b1, 11'h400, 1,  1'b1, 1};
        vecs[2] = '{1'b1, 11'h400, 20, 1'b1, 1};
        vecs[3] = '{1'b0, 11'h400, 2,  1'b1, 1};
        vecs[4] = '{1'b0, 11'h400, 1,  1'b0, 1};
        vecs[5] = '{1'b1, 11'h123, 3,  1'b1, 2};
        vecs[6] = '{1'b0, 11'h123, 3,  1'b0, 2};

        // Reset state
        do_reset();
        check("rst_ack",      {31'b0, r13},      0);
        check("rst_pwm",      {31'b0, pwm},      0);
        check("rst_level",    {27'b0, level},    0);
        check("rst_underrun", {31'b0, underrun}, 0);

        // Handshake latency and single push per request
        for (int i = 0; i < 7; i++) begin
            r14 = vecs[i].req;
            r6  = vecs[i].data;
            repeat (vecs[i].edges) @(negedge clk);
            check($sformatf("vec%0d_ack", i),   {31'b0, r13},   {31'b0, vecs[i].exp_ack});
            check($sformatf("vec%0d_level", i), {27'b0, level}, vecs[i].exp_level);
        end

        // Full FIFO stalls a request until a tick pops a slot
        do_reset();
        for (int i = 0; i < DEPTH; i++) push(SAMPLE_W'(i * 64 + 1));
        check("full_level", {27'b0, level}, 16);
        r6  = 11'h055;
        r14 = 1'b1;
        repeat (10) @(negedge clk);
        check("full_stall_ack",   {31'b0, r13},   0);
        check("full_stall_level", {27'b0, level}, 16);
        wait_to_edge(TDIV - 1);
        check("full_pretick_ack", {31'b0, r13}, 0);
        @(negedge clk);
        check("full_pushpop_ack",   {31'b0, r13},   1);
        check("full_pushpop_level", {27'b0, level}, 16);
        r14 = 1'b0;
        wait_ack(1'b0);

        // Duty cycle, FIFO order, then underrun
        do_reset();
        push(11'd512);
        push(11'd0);
        push(11'd300);
        check("duty_level3", {27'b0, level}, 3);
        wait_to_edge(TDIV + 4);
        measure(hi);
        check("duty_512", hi, 512);
        check("duty_level2", {27'b0, level}, 2);
        wait_to_edge(2 * TDIV + 4);
        measure(hi);
        check("duty_0", hi, 0);
        wait_to_edge(3 * TDIV + 4);
        measure(hi);
        check("duty_300", hi, 300);
        check("pre_underrun", {31'b0, underrun}, 0);
        check("empty_level",  {27'b0, level},    0);
        wait_to_edge(4 * TDIV - 1);
        check("pretick_underrun", {31'b0, underrun}, 0);
        @(negedge clk);
        check("underrun_set", {31'b0, underrun}, 1);
        measure(hi);
        check("underrun_duty_300", hi, 300);
        push(11'h7FF);
        check("underrun_sticky", {31'b0, underrun}, 1);
        check("after_push_level", {27'b0, level}, 1);

        // Reset while holding a request in ACK with samples queued
        push(11'h010);
        push(11'h020);
        push(11'h030);
        r6  = 11'h040;
        r14 = 1'b1;
        wait_ack(1'b1);
        check("midrst_pre_level", {27'b0, level}, 5);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_ack",      {31'b0, r13},      0);
        check("midrst_level",    {27'b0, level},    0);
        check("midrst_underrun", {31'b0, underrun}, 0);
        check("midrst_pwm",      {31'b0, pwm},      0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("reack_early", {31'b0, r13}, 0);
        @(negedge clk);
        check("reack_ack",   {31'b0, r13},   1);
        check("reack_level", {27'b0, level}, 1);
        r14 = 1'b0;
        wait_ack(1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
